// File: rtl/key_schedule_ctrl.sv
// AES-128/192/256 round-key sequencer: steps a combinational expansion stage once per cycle and
// re-packs its Nk-word output into 4-word round keys through a 12-word buffer.
module key_schedule_ctrl (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [1:0]   algorithm_i,
  input  logic [255:0] key_i,
  output logic         busy_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_data_o,
  output logic [3:0]   rk_index_o,
  output logic         rk_last_o,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [1:0]    alg_q, alg_d;
  logic [255:0]  s_q, s_d;
  logic [31:0]   fifo_q [12];
  logic [31:0]   fifo_d [12];
  logic [3:0]    count_q, count_d;
  logic [5:0]    gen_q, gen_d;
  logic [3:0]    iter_q, iter_d;
  logic [3:0]    r_q, r_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [3:0]    nk, nr, nk_in, npush, base;
  logic [5:0]    total, remaining;
  logic [4:0]    pos;
  logic [255:0]  exp_state;
  logic          run, rk_valid, hs, push_en;

  Key_Expansion_new u_key_expansion (
    .state_i     (s_q),
    .algorithm_i (alg_q),
    .round_i     (iter_q),
    .state_o     (exp_state)
  );

  always_comb begin
    case (alg_q)
      2'b01:   begin nk = 4'd6; nr = 4'd12; total = 6'd52; end
      2'b10:   begin nk = 4'd8; nr = 4'd14; total = 6'd60; end
      default: begin nk = 4'd4; nr = 4'd10; total = 6'd44; end
    endcase
    case (algorithm_i)
      2'b01:   nk_in = 4'd6;
      2'b10:   nk_in = 4'd8;
      default: nk_in = 4'd4;
    endcase
  end

  assign run       = (state_q == StRun);
  assign rk_valid  = run && (count_q >= 4'd4);
  assign hs        = rk_valid && rk_ready_i;
  assign remaining = total - gen_q;
  assign npush     = (remaining < {2'b00, nk}) ? remaining[3:0] : nk;
  // Room is judged on the pre-pop count so a full Nk-word burst always fits.
  assign push_en   = run && (gen_q < total) && (({1'b0, count_q} + {1'b0, nk}) <= 5'd12);

  always_comb begin
    state_d = state_q;
    alg_d   = alg_q;
    s_d     = s_q;
    fifo_d  = fifo_q;
    count_d = count_q;
    gen_d   = gen_q;
    iter_d  = iter_q;
    r_d     = r_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    base    = '0;
    pos     = '0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (algorithm_i == 2'b11) begin
            err_d = 1'b1;
          end else begin
            alg_d = algorithm_i;
            s_d   = key_i;
            for (int k = 0; k < 12; k++) fifo_d[k] = '0;
            for (int k = 0; k < 8; k++) begin
              if (4'(k) < nk_in) fifo_d[k] = key_i[255-32*k -: 32];
            end
            count_d = nk_in;
            gen_d   = {2'b00, nk_in};
            iter_d  = 4'd1;
            r_d     = '0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        base = count_q;
        if (hs) begin
          for (int k = 0; k < 8; k++) fifo_d[k] = fifo_q[k+4];
          for (int k = 8; k < 12; k++) fifo_d[k] = '0;
          base = count_q - 4'd4;
          r_d  = r_q + 4'd1;
          if (r_q == nr) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        if (push_en) begin
          s_d = exp_state;
          for (int j = 0; j < 8; j++) begin
            pos = {1'b0, base} + 5'(j);
            if ((4'(j) < npush) && (pos < 5'd12)) fifo_d[pos[3:0]] = exp_state[255-32*j -: 32];
          end
          count_d = base + npush;
          gen_d   = gen_q + {2'b00, npush};
          iter_d  = iter_q + 4'd1;
        end else begin
          count_d = base;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      alg_q   <= '0;
      s_q     <= '0;
      for (int k = 0; k < 12; k++) fifo_q[k] <= '0;
      count_q <= '0;
      gen_q   <= '0;
      iter_q  <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alg_q   <= alg_d;
      s_q     <= s_d;
      for (int k = 0; k < 12; k++) fifo_q[k] <= fifo_d[k];
      count_q <= count_d;
      gen_q   <= gen_d;
      iter_q  <= iter_d;
      r_q     <= r_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy_o     = run;
  assign rk_valid_o = rk_valid;
  assign rk_data_o  = {fifo_q[0], fifo_q[1], fifo_q[2], fifo_q[3]};
  assign rk_index_o = r_q;
  assign rk_last_o  = rk_valid && (r_q == nr);
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// Combinational key-expansion stage: maps the previous Nk words (left-aligned) to the next Nk
// words; words beyond Nk are driven to zero.
module Key_Expansion_new (
  input  logic [255:0] state_i,
  input  logic [1:0]   algorithm_i,
  input  logic [3:0]   round_i,
  output logic [255:0] state_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 via an addition chain, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x240, inv;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  always_comb begin
    logic [31:0] w [8];
    logic [31:0] n [8];
    logic [31:0] last, t;
    logic [7:0]  rcon;
    logic [3:0]  nk;
    for (int i = 0; i < 8; i++) w[i] = state_i[255-32*i -: 32];
    case (algorithm_i)
      2'b01:   begin nk = 4'd6; last = w[5]; end
      2'b10:   begin nk = 4'd8; last = w[7]; end
      default: begin nk = 4'd4; last = w[3]; end
    endcase
    case (round_i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
    t    = sub_word({last[23:0], last[31:24]}) ^ {rcon, 24'h0};
    n[0] = w[0] ^ t;
    n[1] = w[1] ^ n[0];
    n[2] = w[2] ^ n[1];
    n[3] = w[3] ^ n[2];
    n[4] = w[4] ^ ((nk == 4'd8) ? sub_word(n[3]) : n[3]);
    n[5] = w[5] ^ n[4];
    n[6] = w[6] ^ n[5];
    n[7] = w[7] ^ n[6];
    state_o = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nk) state_o[255-32*i -: 32] = n[i];
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed/randomized bench for key_schedule_ctrl against a FIPS-197 key-expansion model.
module tb_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         rst_n, start, rk_ready;
  logic [1:0]   algorithm;
  logic [255:0] key;
  logic         busy, rk_valid, rk_last, done, err;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;

  always #5 clk = ~clk;

  key_schedule_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .algorithm_i (algorithm),
    .key_i       (key),
    .busy_o      (busy),
    .rk_valid_o  (rk_valid),
    .rk_ready_i  (rk_ready),
    .rk_data_o   (rk_data),
    .rk_index_o  (rk_index),
    .rk_last_o   (rk_last),
    .done_o      (done),
    .err_o       (err)
  );

  int           total = 0;
  int           bad = 0;
  logic [7:0]   sbox_t [256];
  logic [31:0]  mw [60];
  int           m_nk, m_nr;
  logic [127:0] got [15];
  logic [127:0] ref128 [15];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // S-box table built by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  task automatic build_model(input logic [255:0] k, input logic [1:0] alg);
    logic [31:0] t;
    logic [7:0]  rc;
    m_nk = (alg == 2'b00) ? 4 : (alg == 2'b01) ? 6 : 8;
    m_nr = m_nk + 6;
    rc   = 8'h01;
    for (int i = 0; i < m_nk; i++) mw[i] = k[255-32*i -: 32];
    for (int i = m_nk; i < 4 * (m_nr + 1); i++) begin
      t = mw[i-1];
      if (i % m_nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (m_nk > 6 && i % m_nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-m_nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, rk_valid, 0);
    check({tag, "_data"}, rk_data, 0);
    check({tag, "_index"}, rk_index, 0);
    check({tag, "_last"}, rk_last, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high; 1: ready low cycles 1-5 then random; 2: ready high plus a
  // stray start in cycle 3. Entered and left in a cycle where the DUT is idle.
  task automatic run_keys(input logic [255:0] k, input logic [1:0] alg, input int mode);
    int           idx, cyc;
    bit           stalled;
    logic [127:0] prev_data;
    logic [3:0]   prev_idx;
    build_model(k, alg);
    key       = k;
    algorithm = alg;
    start     = 1'b1;
    rk_ready  = 1'b1;
    step();
    start   = 1'b0;
    cyc     = 1;
    idx     = 0;
    stalled = 1'b0;
    while (idx <= m_nr && cyc < 300) begin
      rk_ready = (mode == 1) ? ((cyc <= 5) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
      if (mode == 2 && cyc == 3) begin
        start     = 1'b1;
        algorithm = 2'b01;
        key       = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        start = 1'b0;
      end
      check("busy_run", busy, 1);
      if (mode != 1) check("valid_every_cycle", rk_valid, 1);
      if (stalled) begin
        check("stall_valid", rk_valid, 1);
        check("stall_data", rk_data, prev_data);
        check("stall_index", rk_index, prev_idx);
      end
      if (rk_valid) begin
        check("rk_index", rk_index, idx);
        check("rk_data", rk_data, model_rk(idx));
        check("rk_last", rk_last, idx == m_nr);
        got[idx]  = rk_data;
        stalled   = !rk_ready;
        prev_data = rk_data;
        prev_idx  = rk_index;
        if (rk_ready) idx++;
      end else begin
        stalled = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    check("stream_timeout", cyc < 300, 1);
    if (mode != 1) check("done_cycle", cyc, m_nr + 2);
    check("done_pulse", done, 1);
    check("busy_drop", busy, 0);
    check("valid_drop", rk_valid, 0);
  endtask

  initial begin
    int n;
    build_sbox();
    rst_n     = 1'b0;
    start     = 1'b0;
    algorithm = 2'b00;
    key       = '0;
    rk_ready  = 1'b0;
    repeat (2) step();
    check_zero("reset");
    #2 rst_n = 1'b1;
    step();
    check_zero("idle");

    run_keys(K128, 2'b00, 0);
    check("aes128_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("aes128_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int i = 0; i < 11; i++) ref128[i] = got[i];

    run_keys(K192, 2'b01, 0);
    check("aes192_rk1", got[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    check("aes192_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);

    run_keys(K256, 2'b10, 0);
    check("aes256_rk2_w0", got[2][127:96], 32'h9ba35411);
    check("aes256_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

    run_keys(K128, 2'b00, 1);
    for (int i = 0; i < 11; i++) check("backpressure_seq", got[i], ref128[i]);

    start     = 1'b1;
    algorithm = 2'b11;
    step();
    start = 1'b0;
    check("invalid_err", err, 1);
    check("invalid_busy", busy, 0);
    check("invalid_valid", rk_valid, 0);
    step();
    check("invalid_err_once", err, 0);
    check("invalid_busy2", busy, 0);
    check("invalid_valid2", rk_valid, 0);

    run_keys({$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()}, 2'b10, 2);
    for (int i = 0; i < 3; i++) begin
      run_keys({$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()}, 2'(i), 1);
    end

    key       = K256;
    algorithm = 2'b10;
    start     = 1'b1;
    rk_ready  = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (rk_index != 4'd6 && n < 50) begin
      step();
      n++;
    end
    check("reach_round6", rk_index, 6);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_async");
    repeat (3) begin
      step();
      check("no_done_in_reset", done, 0);
    end
    #2 rst_n = 1'b1;
    step();
    check_zero("after_reset");

    run_keys(K128, 2'b00, 0);
    for (int i = 0; i < 11; i++) check("post_reset_seq", got[i], ref128[i]);
    step();
    check("done_one_cycle", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_schedule_ctrl.md
# key_schedule_ctrl

Sequential controller that drives the team's combinational key-expansion stage (Key_Expansion_new, one instance inside this block) one iteration per cycle. It produces the full AES round-key sequence for AES-128, AES-192 and AES-256 as a stream of 128-bit round keys on a valid/ready handshake. It sits between key load and the round datapath. A 12-word buffer re-packs the 4-, 6- or 8-word expansion output into 4-word round keys.

## Interface
- No parameters. Key sizes are fixed by `algorithm`.
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `start`  in  1  Request a new schedule. Sampled only in IDLE.
- `algorithm`  in  2  Key size: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = invalid.
- `key`  in  256  Cipher key, left-aligned. AES-128 uses [255:128]; AES-192 uses [255:64]; unused bits are ignored. Word w0 is [255:224].
- `busy`  out  1  High from the cycle after an accepted `start` until `done`.
- `rk_valid`  out  1  Round key available.
- `rk_ready`  in  1  Consumer accepts the round key.
- `rk_data`  out  128  Round key; w[4r] is in [127:96].
- `rk_index`  out  4  Round number r of `rk_data`, 0..Nr.
- `rk_last`  out  1  High with `rk_valid` when r = Nr.
- `done`  out  1  One-cycle pulse after the last round key is accepted.
- `err`  out  1  One-cycle pulse when `start` arrives with `algorithm` = 11.

## Operation
- Key-size constants:
  - AES-128: Nk = 4, Nr = 10, total 44 words.
  - AES-192: Nk = 6, Nr = 12, total 52 words.
  - AES-256: Nk = 8, Nr = 14, total 60 words.
- States: IDLE, RUN.
- **IDLE + start, algorithm valid:**
  - latch `algorithm`;
  - load the 256-bit expansion state register S from `key`;
  - push w0..w(Nk-1) into the buffer;
  - set gen = Nk, iter = 1, r = 0;
  - go to RUN.
- **IDLE + start, algorithm = 11:** pulse `err`, stay in IDLE, change no other state.
- `start` in RUN is ignored.
- **Expansion datapath connections:** stage input = S; stage algorithm = latched `algorithm`; stage round index (Rcon select) = iter. Index 1..10 selects Rcon 01,02,04,...,1b,36.
- **Push condition:** each RUN cycle with gen < total and count + Nk <= 12, using the count before any pop.
  - S <= stage output;
  - push the first min(Nk, total − gen) new words, taken from the left of the valid output field;
  - gen += pushed words; iter += 1.
- **Iteration counts:** AES-128 uses 10 iterations; AES-192 uses 8, with the last 2 words discarded; AES-256 uses 7, with the last 4 words discarded.
- **Pop:**
  - `rk_valid` = RUN and count >= 4.
  - `rk_data` = the 4 oldest buffer words.
  - On `rk_valid & rk_ready`: pop 4 words and increment r.
- Push and pop in the same cycle are both applied: count' = count − 4 + pushed.
- **Completion:** on the handshake with r = Nr, go to IDLE, pulse `done` in the next cycle, and drop `busy` in that same cycle.
- Buffer capacity is 12 words; it never overflows under the push rule. count is 0..12.

## Timing
- Reset values: state IDLE; all outputs 0. `rk_data` and `rk_index` are 0; buffer, S, count, gen and iter are cleared.
- Latency:
  - `start` is accepted at edge 0.
  - `busy` = 1 and `rk_valid` = 1 with round key 0 (the raw key words) in cycle 1.
- Throughput: with `rk_ready` held high, one round key per cycle for all three key sizes. Keys 0..Nr appear in cycles 1..Nr+1; `done` pulses in cycle Nr+2.
- Backpressure: while `rk_valid & !rk_ready`, `rk_data`, `rk_index` and `rk_last` hold stable. Expansion continues only while the push rule allows.
- `rk_valid` never deasserts without a handshake.
- Reset mid-operation aborts immediately to IDLE. No `done` or `err` is issued.
- `start` in the same cycle as `done` is honoured, because the block is already in IDLE.

## Test plan
- **AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1:**
  - rk1 = a0fafe1788542cb123a339392a6c7605;
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with `rk_last` = 1 in cycle 11;
  - `done` in cycle 12.
- **AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:**
  - rk1 = 62f8ead2522c6b7bfe0c91f72402f5a5;
  - rk12 = e98ba06f448c773c8ecc720401002202;
  - 13 keys in 13 consecutive cycles.
- **AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:**
  - rk2 first word = 9ba35411;
  - rk14 = fe4890d1e6188d0b046df344706c631e at `rk_index` 14.
- **Backpressure:** AES-128 with `rk_ready` low for cycles 1–5, then random 50% toggling.
  - `rk_data` is stable while stalled.
  - The full sequence is identical to the unstalled run.
  - No index is skipped or repeated.
- **Invalid and ignored starts:**
  - `algorithm` = 11 with `start` → `err` pulses once, `busy` stays 0, `rk_valid` stays 0.
  - A second `start` while `busy` → no effect on the stream.
- **Reset mid-run:** assert `rst_n` = 0 during AES-256 round 6.
  - All outputs go to 0 asynchronously; no `done` is issued.
  - A new AES-128 start then produces the correct 11 keys.
